// File: rtl/interp_upsampler.sv
// Linear-interpolating upsampler: drains a standard-mode FIFO and emits one
// interpolated DAC sample per tick, R = 2**LOG2R outputs per input segment.
//
// state  | meaning
// IDLE   | disabled, waiting for ena
// PRIME0 | fetching segment start sample A
// PRIME1 | fetching segment end sample B
// RUN    | interpolating A->B, prefetching N
// HOLD   | segment ran out of data, repeating B until N arrives
module interp_upsampler #(
  parameter int DW    = 12,
  parameter int LOG2R = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          tick,
  input  logic [DW-1:0] fifo_dout,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  output logic [DW-1:0] dac_data,
  output logic          dac_valid,
  output logic          underrun,
  output logic          running
);

  localparam int PW = DW + 1 + LOG2R;
  localparam logic [LOG2R-1:0] K_LAST = '1;

  typedef enum logic [2:0] {IDLE, PRIME0, PRIME1, RUN, HOLD} state_t;

  state_t               state, state_nx;
  logic signed [DW-1:0] a_q, b_q, n_q;
  logic [LOG2R-1:0]     k_q;
  logic                 nvalid, rd_pend, rd_want;
  logic                 cap, seg_end, advance;

  logic signed [DW:0]   diff;
  logic signed [PW-1:0] diff_x, k_x, prod, step, sum;
  logic signed [DW-1:0] interp_y;
  logic                 unused_sum_hi;

  // y = A + floor((B - A) * k / R); result always lies between A and B.
  always_comb begin
    diff          = {b_q[DW-1], b_q} - {a_q[DW-1], a_q};
    diff_x        = PW'(diff);
    k_x           = PW'($signed({1'b0, k_q}));
    prod          = diff_x * k_x;
    step          = prod >>> LOG2R;
    sum           = step + PW'(a_q);
    interp_y      = sum[DW-1:0];
    unused_sum_hi = ^sum[PW-1:DW];
  end

  // A read issued last cycle always lands this cycle; with ena low it is dropped.
  assign cap     = rd_pend & ena;
  assign seg_end = tick && (k_q == K_LAST);
  assign advance = seg_end && (nvalid || cap);

  always_comb begin
    state_nx = state;
    rd_want  = 1'b0;
    case (state)
      IDLE:   if (ena) state_nx = PRIME0;
      PRIME0: begin
        rd_want = 1'b1;
        if (cap) state_nx = PRIME1;
      end
      PRIME1: begin
        rd_want = 1'b1;
        if (cap) state_nx = RUN;
      end
      RUN: begin
        rd_want = ~nvalid;
        if (seg_end && !advance) state_nx = HOLD;
      end
      HOLD: begin
        rd_want = 1'b1;
        if (cap) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
    if (!ena) state_nx = IDLE;
    fifo_rd_en = ena && rd_want && !fifo_empty && !rd_pend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
      nvalid    <= 1'b0;
      rd_pend   <= 1'b0;
      dac_data  <= '0;
      dac_valid <= 1'b0;
      underrun  <= 1'b0;
      running   <= 1'b0;
    end else begin
      rd_pend   <= fifo_rd_en;
      running   <= (state_nx == RUN) || (state_nx == HOLD);
      dac_valid <= 1'b0;
      if (!ena) begin
        k_q    <= '0;
        nvalid <= 1'b0;
      end else begin
        case (state)
          PRIME0: if (cap) a_q <= fifo_dout;
          PRIME1: begin
            if (cap) begin
              b_q <= fifo_dout;
              k_q <= '0;
            end
          end
          RUN: begin
            if (cap) begin
              n_q    <= fifo_dout;
              nvalid <= 1'b1;
            end
            if (tick) begin
              dac_data  <= interp_y;
              dac_valid <= 1'b1;
              k_q       <= k_q + 1'b1;
            end
            // Bypass: a sample landing on the last tick advances the segment directly.
            if (advance) begin
              a_q    <= b_q;
              b_q    <= nvalid ? n_q : fifo_dout;
              nvalid <= 1'b0;
            end else if (seg_end) begin
              underrun <= 1'b1;
            end
          end
          HOLD: begin
            if (tick) begin
              dac_data  <= b_q;
              dac_valid <= 1'b1;
            end
            if (cap) begin
              a_q    <= b_q;
              b_q    <= fifo_dout;
              nvalid <= 1'b0;
              k_q    <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/interp_upsampler.md
Name: interp_upsampler

Overview:
- Read-side counterpart of the max-decimation path: drains down-rate samples from a standard-mode (non-FWFT) FIFO and rebuilds a higher-rate stream for the DAC.
- Interpolates linearly by R = 2^LOG2R between consecutive samples and emits one output per `tick` strobe.
- Single clock domain; sits between the FIFO read port and the DAC driver.

Parameters:
- DW, 12, signed sample width (FIFO data and DAC data).
- LOG2R, 3, log2 of the interpolation factor (R = 8).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  run enable; low forces IDLE.
- tick  in  1  output-rate strobe, one cycle wide; at least 2 clk between ticks.
- fifo_dout  in  DW  signed FIFO read data, valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read request.
- dac_data  out  DW  signed interpolated sample.
- dac_valid  out  1  one-cycle pulse, dac_data updated.
- underrun  out  1  sticky: interpolation segment ended with no next sample available.
- running  out  1  high in RUN or HOLD.

Behaviour:
- Reset (rst_n low, async): all outputs 0; state IDLE; registers A, B, N, k, nvalid, rd_pend all cleared.
- Registers:
  - A = segment start sample; B = segment end sample; N = prefetched next sample.
  - nvalid = N holds data; k = phase counter, LOG2R bits.
- Read rule:
  - fifo_rd_en asserted only when fifo_empty = 0 and no read is pending (rd_pend = 0).
  - fifo_dout is captured exactly 1 cycle after fifo_rd_en.
  - Never read while nvalid = 1.
- States:
  - IDLE: ena = 1 -> PRIME0.
  - PRIME0: read -> capture into A -> PRIME1.
  - PRIME1: read -> capture into B -> RUN with k = 0. running goes high.
  - RUN:
    - Prefetch into N whenever nvalid = 0.
    - On tick, output y = A + ((B - A) * k) >>> LOG2R, then k <= k + 1.
    - On a tick with k = R-1 and nvalid = 1: A <= B, B <= N, nvalid <= 0, k <= 0.
    - On a tick with k = R-1 and nvalid = 0: underrun <= 1, go to HOLD.
  - HOLD:
    - Each tick outputs B.
    - When N captured: A <= B, B <= N, nvalid <= 0, k <= 0, go to RUN. The next tick outputs the new A.
  - Any state, ena low: IDLE next cycle. k, nvalid and running cleared. A read already issued completes and its data is discarded. dac_data keeps its last value. underrun is retained.
- Arithmetic:
  - B - A computed in DW+1 bits signed.
  - Product in DW+1+LOG2R bits.
  - Arithmetic right shift, floor toward -inf.
  - Sum truncated to DW bits; it never overflows because y lies between A and B.
- Latency: tick in cycle t -> dac_valid = 1 and new dac_data in cycle t+1.
- Ticks in IDLE/PRIME: ignored, no dac_valid, no underrun.
- Simultaneous tick at k = R-1 and the N capture in the same cycle: the capture is treated as nvalid = 1 (bypass). Segment advances, no underrun.
- underrun: cleared only by reset.

Test Plan:
- Continuous ramp: FIFO 0, 80, 160, 240, ticks every 4 clk -> dac_data 0, 10, 20, …, 70, 80, 90, …, 150. No underrun. No rd_en while fifo_empty = 1.
- Negative slope: FIFO 100, -60, -60 -> 100, 80, 60, 40, 20, 0, -20, -40, then -60 ×8.
- Floor rounding: FIFO 0, -1, 0 -> 0, -1, -1, -1, -1, -1, -1, -1, then -1, -1, -1, -1, -1, -1, -1, -1 (k = 0..7 of the -1→0 segment floor to -1).
- Underrun: FIFO 0, 8, then empty for 20 ticks -> 0..7, then 8 repeated, underrun = 1. Push 16 -> segment 8→16 gives 8, 9, …, 15; underrun stays 1.
- Bypass: N arrives in the same cycle as the k = 7 tick -> clean segment advance, underrun = 0.
- Reset mid-segment (k = 5): rst_n low -> all outputs 0 immediately. After release with ena = 1, PRIME restarts and two fresh FIFO reads precede any dac_valid.
